snic_tx_arbiter: RTL

SNIC_TX_ARBITER -- requirements
Module: snic_tx_arbiter

---
 rtl/snic_tx_arbiter_if.sv | 17 +
 rtl/snic_tx_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/snic_tx_arbiter_if.sv
// AXI-Stream style bundle shared by the two egress sources and the merged network egress.
// tuser is driven only on the merged output; sources leave it unused.
interface snic_tx_arbiter_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tdest;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;

  modport master (output tdata, tkeep, tdest, tlast, tvalid, tuser, input tready);
  modport slave  (input tdata, tkeep, tdest, tlast, tvalid, output tready);
endinterface

// File: rtl/snic_tx_arbiter.sv
// Packet-granular two-way arbiter merging TCP and endpoint egress onto one network stream,
// with a single output register and per-source packet counters.
//
// state       | meaning
// ST_IDLE     | no grant; both source treadys low, picks next owner from tvalids
// ST_BUSY_TCP | tcp owns the output until its tlast beat is accepted
// ST_BUSY_EP  | ep owns the output until its tlast beat is accepted
module snic_tx_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                      net_clk,
  input  logic                      net_aresetn,
  snic_tx_arbiter_if.slave          s_axis_tcp,
  snic_tx_arbiter_if.slave          s_axis_ep,
  snic_tx_arbiter_if.master         m_axis_tx,
  output logic [31:0]               pkt_cnt_tcp,
  output logic [31:0]               pkt_cnt_ep
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BUSY_TCP = 2'd1;
  localparam logic [1:0] ST_BUSY_EP  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [KEEP_WIDTH-1:0] out_keep_q;
  logic                  out_dest_q;
  logic                  out_last_q;
  logic                  out_user_q;
  logic [31:0]           cnt_tcp_q, cnt_ep_q;
  logic                  out_free, tcp_ready, ep_ready, tcp_acc, ep_acc;

  assign out_free  = ~out_valid_q | m_axis_tx.tready;
  assign tcp_ready = (state_q == ST_BUSY_TCP) & out_free;
  assign ep_ready  = (state_q == ST_BUSY_EP) & out_free;
  assign tcp_acc   = tcp_ready & s_axis_tcp.tvalid;
  assign ep_acc    = ep_ready & s_axis_ep.tvalid;

  assign s_axis_tcp.tready = tcp_ready;
  assign s_axis_ep.tready  = ep_ready;

  // Ties go to whichever source did not own the previous packet.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_tcp.tvalid && s_axis_ep.tvalid) begin
          if (last_grant_q) begin
            state_d      = ST_BUSY_TCP;
            last_grant_d = 1'b0;
          end else begin
            state_d      = ST_BUSY_EP;
            last_grant_d = 1'b1;
          end
        end else if (s_axis_tcp.tvalid) begin
          state_d      = ST_BUSY_TCP;
          last_grant_d = 1'b0;
        end else if (s_axis_ep.tvalid) begin
          state_d      = ST_BUSY_EP;
          last_grant_d = 1'b1;
        end
      end
      ST_BUSY_TCP: if (tcp_acc && s_axis_tcp.tlast) state_d = ST_IDLE;
      ST_BUSY_EP:  if (ep_acc && s_axis_ep.tlast) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_dest_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
    end else if (tcp_acc) begin
      out_valid_q <= 1'b1;
      out_data_q  <= s_axis_tcp.tdata;
      out_keep_q  <= s_axis_tcp.tkeep;
      out_dest_q  <= s_axis_tcp.tdest;
      out_last_q  <= s_axis_tcp.tlast;
      out_user_q  <= 1'b0;
    end else if (ep_acc) begin
      out_valid_q <= 1'b1;
      out_data_q  <= s_axis_ep.tdata;
      out_keep_q  <= s_axis_ep.tkeep;
      out_dest_q  <= s_axis_ep.tdest;
      out_last_q  <= s_axis_ep.tlast;
      out_user_q  <= 1'b1;
    end else if (m_axis_tx.tready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      cnt_tcp_q <= '0;
      cnt_ep_q  <= '0;
    end else begin
      if (tcp_acc && s_axis_tcp.tlast) cnt_tcp_q <= cnt_tcp_q + 32'd1;
      if (ep_acc && s_axis_ep.tlast)   cnt_ep_q  <= cnt_ep_q + 32'd1;
    end
  end

  assign m_axis_tx.tvalid = out_valid_q;
  assign m_axis_tx.tdata  = out_data_q;
  assign m_axis_tx.tkeep  = out_keep_q;
  assign m_axis_tx.tdest  = out_dest_q;
  assign m_axis_tx.tlast  = out_last_q;
  assign m_axis_tx.tuser  = out_user_q;
  assign pkt_cnt_tcp      = cnt_tcp_q;
  assign pkt_cnt_ep       = cnt_ep_q;

endmodule
